// File: rtl/ad7264_conversion_sequencer_pkg.sv
// Shared types and default geometry for the AD7264 conversion sequencer.
package ad7264_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  localparam int FRAME_BITS_DEF = 32;
  localparam int CW_BITS_DEF    = 16;
  localparam int DATA_BITS_DEF  = 14;
  localparam int CAP_START_DEF  = 3;
  localparam int QUIET_CLKS_DEF = 4;

  // Control-word framing: MSB goes out first, an all-zero word leaves the part untouched.
  localparam int                     CW_MSB = CW_BITS_DEF - 1;
  localparam logic [CW_BITS_DEF-1:0] CW_NOP = '0;

endpackage

// File: rtl/ad7264_conversion_sequencer_sclk_edge_detect.sv
// One-cycle rise/fall pulses from the fed-back SPI clock.
// spi_sclk is generated from Clk, so a single register stage is enough.
module sclk_edge_detect (
  input  logic Clk,
  input  logic reset,
  input  logic sclk,
  output logic rise,
  output logic fall
);

  logic sclk_q;

  always_ff @(posedge Clk) begin
    if (reset) sclk_q <= 1'b0;
    else       sclk_q <= sclk;
  end

  assign rise = sclk & ~sclk_q;
  assign fall = ~sclk & sclk_q;

endmodule

// File: rtl/ad7264_conversion_sequencer.sv
// Drives one AD7264 frame through the SPI master and returns both channel samples.
//   state | meaning
//   IDLE  | ss low, waiting for start
//   ARM   | ss high, first SCLK rise loads the master's select flop
//   SHIFT | control word out on DIM, samples in from DOMA/DOMB
//   GAP   | ss low for QUIET_CLKS cycles before the next frame
module ad7264_conversion_sequencer
  import ad7264_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CW_BITS    = CW_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int CAP_START  = CAP_START_DEF,
  parameter int QUIET_CLKS = QUIET_CLKS_DEF
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW_BITS-1:0]   control_word,
  output logic                 busy,
  input  logic                 spi_sclk,
  output logic                 ss,
  output logic                 startSending,
  output logic                 DIM,
  input  logic                 DOMA,
  input  logic                 DOMB,
  output logic [DATA_BITS-1:0] sample_a,
  output logic [DATA_BITS-1:0] sample_b,
  output logic                 sample_valid
);

  localparam int CNT_W = $clog2(FRAME_BITS) + 1;
  localparam int GAP_W = $clog2(QUIET_CLKS) + 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CAP_LO   = CNT_W'(CAP_START);
  localparam logic [CNT_W-1:0] CAP_HI   = CNT_W'(CAP_START + DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CW_LAST  = CNT_W'(CW_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(QUIET_CLKS - 1);

  seq_state_t state, state_nxt;

  logic                 sclk_rise, sclk_fall;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CW_BITS-1:0]   cw_sr;
  logic [DATA_BITS-1:0] sh_a, sh_b;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 tx_en;

  logic accept, shift_rise, frame_end, cap_bit;

  sclk_edge_detect u_edge (
    .Clk   (Clk),
    .reset (reset),
    .sclk  (spi_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign accept     = (state == IDLE) && start;
  assign shift_rise = (state == SHIFT) && sclk_rise;
  assign frame_end  = shift_rise && (bit_cnt == LAST_BIT);
  assign cap_bit    = shift_rise && (bit_cnt >= CAP_LO) && (bit_cnt <= CAP_HI);

  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)             state_nxt = ARM;
      ARM:     if (sclk_rise)         state_nxt = SHIFT;
      SHIFT:   if (frame_end)         state_nxt = GAP;
      GAP:     if (gap_cnt == '0)     state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b1;
    ss           = 1'b0;
    startSending = 1'b0;
    DIM          = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      ARM, SHIFT: begin
        ss           = 1'b1;
        startSending = tx_en;
        DIM          = cw_sr[CW_BITS-1];
      end
      default: ;
    endcase
  end

  // The ARM-to-SHIFT rise only loads the master's select flop, so nothing shifts on it.
  always_ff @(posedge Clk) begin
    if (reset) begin
      bit_cnt <= '0;
      cw_sr   <= '0;
      tx_en   <= 1'b0;
    end else if (accept) begin
      bit_cnt <= '0;
      cw_sr   <= control_word;
      tx_en   <= 1'b1;
    end else if (shift_rise) begin
      bit_cnt <= bit_cnt + 1'b1;
      cw_sr   <= {cw_sr[CW_BITS-2:0], 1'b0};
      tx_en   <= (bit_cnt < CW_LAST);
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      sh_a <= '0;
      sh_b <= '0;
    end else if (accept) begin
      sh_a <= '0;
      sh_b <= '0;
    end else if (cap_bit) begin
      sh_a <= {sh_a[DATA_BITS-2:0], DOMA};
      sh_b <= {sh_b[DATA_BITS-2:0], DOMB};
    end
  end

  always_ff @(posedge Clk) begin
    if (reset)                             gap_cnt <= '0;
    else if (frame_end)                    gap_cnt <= GAP_LOAD;
    else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      sample_a     <= '0;
      sample_b     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= frame_end;
      if (frame_end) begin
        sample_a <= sh_a;
        sample_b <= sh_b;
      end
    end
  end

  // Each SCLK half-period must last at least two Clk cycles for DIM to settle.
  a_sclk_high_min: assert property (@(posedge Clk) disable iff (reset) sclk_rise |=> !sclk_fall);
  a_sclk_low_min:  assert property (@(posedge Clk) disable iff (reset) sclk_fall |=> !sclk_rise);

endmodule

// File: tb/tb_ad7264_conversion_sequencer.sv
// Directed bench: SPI master modelled around the sequencer, samples scored through a queue.
module tb_ad7264_conversion_sequencer;

  localparam int QUIET = 4;

  logic        Clk = 1'b0;
  logic        reset, start, spi_sclk, DOMA, DOMB;
  logic [15:0] control_word;
  logic        busy, ss, startSending, DIM, sample_valid;
  logic [13:0] sample_a, sample_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [27:0] pair_t;
  pair_t exp_q[$];

  logic        in_frame = 1'b0, abort = 1'b0;
  int          nrise = 0, frames = 0, valid_cnt = 0, ss_low_run = 0;
  logic [39:0] st_mask;
  logic [15:0] dim_word, cur_cw;
  logic        dim_tail;
  logic [13:0] mdl_a, mdl_b;
  logic        valid_prev = 1'b0, b2b = 1'b0, gap_armed = 1'b0;

  ad7264_conversion_sequencer #(
    .FRAME_BITS (32),
    .CW_BITS    (16),
    .DATA_BITS  (14),
    .CAP_START  (3),
    .QUIET_CLKS (QUIET)
  ) dut (
    .Clk          (Clk),
    .reset        (reset),
    .start        (start),
    .control_word (control_word),
    .busy         (busy),
    .spi_sclk     (spi_sclk),
    .ss           (ss),
    .startSending (startSending),
    .DIM          (DIM),
    .DOMA         (DOMA),
    .DOMB         (DOMB),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .sample_valid (sample_valid)
  );

  always #5 Clk = ~Clk;

  // SCLK = Clk/8, edges offset from the Clk edges
  initial begin
    spi_sclk = 1'b0;
    #2;
    forever #40 spi_sclk = ~spi_sclk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Frame observer, sampling as the master would at each SCLK rise
  initial forever begin
    @(posedge ss);
    in_frame = 1'b1;
    nrise    = 0;
    st_mask  = '0;
    dim_word = '0;
    dim_tail = 1'b0;
    frames++;
  end

  initial forever begin
    @(posedge spi_sclk);
    if (in_frame && ss === 1'b1) begin
      if (startSending === 1'b1 && nrise < 40) st_mask[nrise] = 1'b1;
      if (nrise >= 1 && nrise <= 16) dim_word = {dim_word[14:0], DIM};
      else if (nrise > 16 && DIM !== 1'b0) dim_tail = 1'b1;
      nrise++;
    end
  end

  // 33 rises with ss high; startSending high across rises 0..16 = 16 full SCLK periods
  initial forever begin
    @(negedge ss);
    if (in_frame && !abort) begin
      chk("ss_rise_count", nrise, 33);
      chk("startsending_window", st_mask, 40'h1FFFF);
      chk("dim_word", dim_word, cur_cw);
      chk("dim_zero_fill", dim_tail, 1'b0);
    end
    in_frame = 1'b0;
    abort    = 1'b0;
  end

  // ADC + master model: 00, then 14 sample bits MSB first, one SCLK register delay
  initial begin
    int i;
    DOMA = 1'b0;
    DOMB = 1'b0;
    forever begin
      @(negedge spi_sclk);
      i = nrise - 2;
      if (in_frame && i >= 2 && i <= 15) begin
        DOMA = mdl_a[15-i];
        DOMB = mdl_b[15-i];
      end else begin
        DOMA = 1'b0;
        DOMB = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    pair_t e;
    forever begin
      @(negedge Clk);
      if (ss === 1'b1) begin
        if (gap_armed) begin
          chk("b2b_ss_low_gap", ss_low_run, QUIET + 1);
          gap_armed = 1'b0;
        end
        ss_low_run = 0;
      end else begin
        ss_low_run++;
      end
      if (sample_valid === 1'b1) begin
        valid_cnt++;
        chk("valid_after_last_rise", ss_low_run, 1);
        chk("valid_single_pulse", valid_prev, 1'b0);
        chk("valid_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sample_a", sample_a, e[27:14]);
          chk("sample_b", sample_b, e[13:0]);
        end
        if (b2b) gap_armed = 1'b1;
      end
      valid_prev = sample_valid;
    end
  end

  task automatic do_start(input logic [15:0] cw, input logic [13:0] a, input logic [13:0] b);
    @(negedge Clk);
    control_word = cw;
    cur_cw       = cw;
    mdl_a        = a;
    mdl_b        = b;
    start        = 1'b1;
    exp_q.push_back({a, b});
    @(negedge Clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("ss_after_start", ss, 1'b1);
  endtask

  task automatic wait_valid(input int n, input int budget);
    int c = 0;
    while (valid_cnt < n && c < budget) begin
      @(negedge Clk);
      #1;
      c++;
    end
    chk("wait_valid_in_time", valid_cnt >= n, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      @(negedge Clk);
      #1;
      c++;
    end
    chk("wait_idle_in_time", busy, 1'b0);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int c = 0;
    while (nrise < n && c < budget) begin
      @(posedge spi_sclk);
      #1;
      c++;
    end
    chk("reach_rise_count", nrise, n);
  endtask

  initial begin
    int fb, vb, hi;
    reset        = 1'b1;
    start        = 1'b0;
    control_word = '0;
    cur_cw       = '0;
    mdl_a        = '0;
    mdl_b        = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ss", ss, 1'b0);
    chk("rst_startsending", startSending, 1'b0);
    chk("rst_dim", DIM, 1'b0);
    chk("rst_sample_a", sample_a, 14'h0);
    chk("rst_sample_b", sample_b, 14'h0);
    chk("rst_sample_valid", sample_valid, 1'b0);
    reset = 1'b0;

    // control word + capture
    do_start(16'hA5C3, 14'h2ABC, 14'h1357);
    wait_valid(1, 400);
    wait_idle(20);
    repeat (10) @(negedge Clk);
    chk("sample_a_hold", sample_a, 14'h2ABC);
    chk("sample_b_hold", sample_b, 14'h1357);

    // capture window edges: first and last sample bits
    do_start(16'h8001, 14'h3FFF, 14'h0001);
    wait_valid(2, 400);
    wait_idle(20);

    // back-to-back with start held high; stop after the third result
    @(negedge Clk);
    b2b          = 1'b1;
    control_word = 16'h0F0F;
    cur_cw       = 16'h0F0F;
    mdl_a        = 14'h0001;
    mdl_b        = 14'h2000;
    repeat (3) exp_q.push_back({14'h0001, 14'h2000});
    fb    = frames;
    vb    = valid_cnt;
    start = 1'b1;
    wait_valid(vb + 3, 1300);
    start = 1'b0;
    wait_idle(20);
    b2b       = 1'b0;
    gap_armed = 1'b0;
    chk("b2b_frame_count", frames - fb, 3);
    chk("b2b_valid_count", valid_cnt - vb, 3);

    // start on the same cycle as the final rise is ignored
    do_start(16'h3C5A, 14'h0AAA, 14'h1555);
    wait_rises(33, 60);
    fb    = frames;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("end_start_busy_gap0", busy, 1'b1);
    for (int k = 1; k < QUIET; k++) begin
      @(negedge Clk);
      chk("end_start_busy_gap", busy, 1'b1);
    end
    @(negedge Clk);
    chk("end_start_idle", busy, 1'b0);
    hi = 0;
    repeat (8) begin
      @(negedge Clk);
      if (ss === 1'b1) hi++;
    end
    chk("end_start_no_frame", hi, 0);
    chk("end_start_frames", frames - fb, 0);
    do_start(16'h5A3C, 14'h2001, 14'h1002);
    wait_valid(vb + 5, 400);
    wait_idle(20);

    // reset with bit_cnt at 10
    do_start(16'hFFFF, 14'h1111, 14'h2222);
    wait_rises(11, 30);
    @(negedge Clk);
    abort = 1'b1;
    exp_q.delete();
    reset = 1'b1;
    @(negedge Clk);
    chk("abort_ss", ss, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_startsending", startSending, 1'b0);
    chk("abort_sample_valid", sample_valid, 1'b0);
    chk("abort_sample_a", sample_a, 14'h0);
    chk("abort_sample_b", sample_b, 14'h0);
    reset = 1'b0;
    vb    = valid_cnt;
    repeat (40) @(negedge Clk);
    #1;
    chk("abort_no_valid", valid_cnt - vb, 0);

    // normal frame after the abort
    do_start(16'h1234, 14'h3210, 14'h0123);
    wait_valid(vb + 1, 400);
    wait_idle(20);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
